// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around the port arbiter.
// The master modport is the arbiter's view; the slave modport is the requesters' and memory's view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [3:0]        ls_be;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and load/store,
// with read-return routing, a quiesce handshake and a saturating stall counter.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.master   bus,
    input  logic                 quiesce,
    output logic                 idle,
    output logic [15:0]          stall_cnt
);
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    logic                   last_owner_q, last_owner_d;
    logic [MEM_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [MEM_LATENCY-1:0] pipe_own_q, pipe_own_d;
    logic [15:0]            stall_cnt_q, stall_cnt_d;

    logic              if_gnt;
    logic              ls_gnt;
    logic              push_vld;
    logic              stalled;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (!quiesce) begin
            if (bus.if_req && bus.ls_req) begin
                if_gnt = (last_owner_q == OWN_LS);
                ls_gnt = (last_owner_q == OWN_IF);
            end else begin
                if_gnt = bus.if_req;
                ls_gnt = bus.ls_req;
            end
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = bus.if_addr;
        mem_wdata = bus.ls_wdata;
        if (if_gnt) begin
            mem_be = 4'hF;
        end else if (ls_gnt) begin
            mem_we   = bus.ls_we;
            mem_be   = bus.ls_be;
            mem_addr = bus.ls_addr;
        end
    end

    // Stores occupy a pipeline slot as an invalid entry so later reads keep their timing.
    always_comb begin
        last_owner_d = last_owner_q;
        if (if_gnt) begin
            last_owner_d = OWN_IF;
        end else if (ls_gnt) begin
            last_owner_d = OWN_LS;
        end

        push_vld      = if_gnt | (ls_gnt & ~bus.ls_we);
        pipe_vld_d    = pipe_vld_q;
        pipe_own_d    = pipe_own_q;
        pipe_vld_d[0] = push_vld;
        pipe_own_d[0] = ls_gnt ? OWN_LS : OWN_IF;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_own_d[i] = pipe_own_q[i-1];
        end

        stalled     = (bus.if_req & ~if_gnt) | (bus.ls_req & ~ls_gnt);
        stall_cnt_d = stall_cnt_q;
        if (stalled && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner_q <= OWN_LS;
            pipe_vld_q   <= '0;
            pipe_own_q   <= '0;
            stall_cnt_q  <= 16'h0000;
        end else begin
            last_owner_q <= last_owner_d;
            pipe_vld_q   <= pipe_vld_d;
            pipe_own_q   <= pipe_own_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.ls_gnt    = ls_gnt;
    assign bus.mem_req   = if_gnt | ls_gnt;
    assign bus.mem_we    = mem_we;
    assign bus.mem_be    = mem_be;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;

    assign bus.if_rvalid = pipe_vld_q[MEM_LATENCY-1] & (pipe_own_q[MEM_LATENCY-1] == OWN_IF);
    assign bus.ls_rvalid = pipe_vld_q[MEM_LATENCY-1] & (pipe_own_q[MEM_LATENCY-1] == OWN_LS);
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.ls_rdata  = bus.mem_rdata;

    assign idle      = ~(if_gnt | ls_gnt) & ~(|pipe_vld_q);
    assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances at MEM_LATENCY 1, 2 and 3 share one stimulus and
// memory model; returned reads are checked against a per-instance queue of expected returns.
module tb_mem_port_arbiter;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        if_req, ls_req, ls_we, quiesce;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [3:0]  ls_be;

    logic        if_gnt_v [ND];
    logic        ls_gnt_v [ND];
    logic        if_rv_v  [ND];
    logic        ls_rv_v  [ND];
    logic        mreq_v   [ND];
    logic        mwe_v    [ND];
    logic        idle_v   [ND];
    logic [3:0]  mbe_v    [ND];
    logic [31:0] maddr_v  [ND];
    logic [31:0] mwdata_v [ND];
    logic [31:0] if_rd_v  [ND];
    logic [31:0] ls_rd_v  [ND];
    logic [15:0] stall_v  [ND];

    logic [31:0] mem   [256];
    logic [31:0] rpipe [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
        assign bus.if_req    = if_req;
        assign bus.if_addr   = if_addr;
        assign bus.ls_req    = ls_req;
        assign bus.ls_we     = ls_we;
        assign bus.ls_be     = ls_be;
        assign bus.ls_addr   = ls_addr;
        assign bus.ls_wdata  = ls_wdata;
        assign bus.mem_rdata = rpipe[g];
        assign if_gnt_v[g]   = bus.if_gnt;
        assign ls_gnt_v[g]   = bus.ls_gnt;
        assign if_rv_v[g]    = bus.if_rvalid;
        assign ls_rv_v[g]    = bus.ls_rvalid;
        assign if_rd_v[g]    = bus.if_rdata;
        assign ls_rd_v[g]    = bus.ls_rdata;
        assign mreq_v[g]     = bus.mem_req;
        assign mwe_v[g]      = bus.mem_we;
        assign mbe_v[g]      = bus.mem_be;
        assign maddr_v[g]    = bus.mem_addr;
        assign mwdata_v[g]   = bus.mem_wdata;

        mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(g + 1)) u_dut (
            .clk       (clk),
            .rst       (rst_n),
            .bus       (bus),
            .quiesce   (quiesce),
            .idle      (idle_v[g]),
            .stall_cnt (stall_v[g])
        );
    end

    // Memory read path: the word at the accepted address appears g+1 cycles later on instance g.
    always @(posedge clk) begin
        rpipe[0] <= mem[maddr_v[0][9:2]];
        for (int i = 1; i < ND; i++) rpipe[i] <= rpipe[i-1];
    end

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        lr;
        logic        lw;
        logic [3:0]  lb;
        logic [31:0] la;
        logic [31:0] wd;
        logic        q;
        logic        e_ig;
        logic        e_lg;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr;
        logic [15:0] e_stall;
    } vec_t;

    typedef struct {
        logic        owner;
        logic [31:0] data;
        int          due;
    } sb_t;

    sb_t sbq [ND][$];
    int  cyc = 0;
    int  tot = 0;
    int  bad = 0;
    vec_t tbl [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic lr,
                                input logic lw, input logic [3:0] lb, input logic [31:0] la,
                                input logic [31:0] wd, input logic q, input logic e_ig,
                                input logic e_lg, input logic e_we, input logic [3:0] e_be,
                                input logic [31:0] e_addr, input logic [15:0] e_stall);
        vec_t v;
        v.ir = ir; v.ia = ia; v.lr = lr; v.lw = lw; v.lb = lb; v.la = la; v.wd = wd; v.q = q;
        v.e_ig = e_ig; v.e_lg = e_lg; v.e_we = e_we; v.e_be = e_be;
        v.e_addr = e_addr; v.e_stall = e_stall;
        return v;
    endfunction

    task automatic drive(input logic ir, input logic [31:0] ia, input logic lr, input logic lw,
                         input logic [3:0] lb, input logic [31:0] la, input logic [31:0] wd,
                         input logic q);
        if_req = ir; if_addr = ia; ls_req = lr; ls_we = lw;
        ls_be = lb; ls_addr = la; ls_wdata = wd; quiesce = q;
    endtask

    // Per-cycle scoreboard: compare returns due this cycle, apply stores, queue new reads.
    task automatic sb();
        sb_t e;
        if (!rst_n) begin
            for (int d = 0; d < ND; d++) sbq[d].delete();
            return;
        end
        cyc++;
        for (int d = 0; d < ND; d++) begin
            if (sbq[d].size() != 0 && sbq[d][0].due == cyc) begin
                e = sbq[d].pop_front();
                chk($sformatf("if_rvalid_d%0d", d), if_rv_v[d], !e.owner);
                chk($sformatf("ls_rvalid_d%0d", d), ls_rv_v[d], e.owner);
                chk($sformatf("rdata_d%0d", d), e.owner ? ls_rd_v[d] : if_rd_v[d], e.data);
            end else begin
                chk($sformatf("no_if_rvalid_d%0d", d), if_rv_v[d], 1'b0);
                chk($sformatf("no_ls_rvalid_d%0d", d), ls_rv_v[d], 1'b0);
            end
            if (if_gnt_v[d]) begin
                e.owner = 1'b0; e.data = mem[if_addr[9:2]]; e.due = cyc + d + 1;
                sbq[d].push_back(e);
            end else if (ls_gnt_v[d] && !ls_we) begin
                e.owner = 1'b1; e.data = mem[ls_addr[9:2]]; e.due = cyc + d + 1;
                sbq[d].push_back(e);
            end
        end
        if (mreq_v[0] && mwe_v[0]) begin
            for (int b = 0; b < 4; b++)
                if (mbe_v[0][b]) mem[maddr_v[0][9:2]][8*b +: 8] = mwdata_v[0][8*b +: 8];
        end
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
        sb();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h5A5A_0000 | 32'(i);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 4'h0, 0, 0, 0);

        tbl[0]  = mk(1, 32'h10, 1, 0, 4'hF, 32'h100, 0, 0,  1, 0, 0, 4'hF, 32'h10,  16'd0);
        tbl[1]  = mk(1, 32'h14, 1, 0, 4'hF, 32'h100, 0, 0,  0, 1, 0, 4'hF, 32'h100, 16'd1);
        tbl[2]  = mk(1, 32'h14, 1, 0, 4'hF, 32'h104, 0, 0,  1, 0, 0, 4'hF, 32'h14,  16'd2);
        tbl[3]  = mk(1, 32'h18, 1, 0, 4'hF, 32'h104, 0, 0,  0, 1, 0, 4'hF, 32'h104, 16'd3);
        tbl[4]  = mk(1, 32'h0,  0, 0, 4'h0, 32'h0,   0, 0,  1, 0, 0, 4'hF, 32'h0,   16'd4);
        tbl[5]  = mk(1, 32'h4,  0, 0, 4'h0, 32'h0,   0, 0,  1, 0, 0, 4'hF, 32'h4,   16'd4);
        tbl[6]  = mk(1, 32'h8,  0, 0, 4'h0, 32'h0,   0, 0,  1, 0, 0, 4'hF, 32'h8,   16'd4);
        tbl[7]  = mk(1, 32'hC,  0, 0, 4'h0, 32'h0,   0, 0,  1, 0, 0, 4'hF, 32'hC,   16'd4);
        tbl[8]  = mk(0, 32'h0,  1, 1, 4'h3, 32'h40, 32'hDEADBEEF, 0, 0, 1, 1, 4'h3, 32'h40, 16'd4);
        tbl[9]  = mk(0, 32'h0,  1, 0, 4'hF, 32'h40,  0, 0,  0, 1, 0, 4'hF, 32'h40,  16'd4);
        tbl[10] = mk(1, 32'h1C, 1, 0, 4'hF, 32'h108, 0, 1,  0, 0, 0, 4'h0, 32'h0,   16'd4);
        tbl[11] = mk(1, 32'h1C, 1, 0, 4'hF, 32'h108, 0, 1,  0, 0, 0, 4'h0, 32'h0,   16'd5);
        tbl[12] = mk(0, 32'h0,  0, 0, 4'h0, 32'h0,   0, 0,  0, 0, 0, 4'h0, 32'h0,   16'd6);
        tbl[13] = mk(1, 32'h1C, 1, 0, 4'hF, 32'h108, 0, 0,  1, 0, 0, 4'hF, 32'h1C,  16'd6);
        tbl[14] = mk(0, 32'h0,  0, 0, 4'h0, 32'h0,   0, 0,  0, 0, 0, 4'h0, 32'h0,   16'd7);

        repeat (2) begin next(); settle(); end
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("rst_stall_d%0d", d), stall_v[d], 16'd0);
            chk($sformatf("rst_idle_d%0d", d), idle_v[d], 1'b1);
            chk($sformatf("rst_mreq_d%0d", d), mreq_v[d], 1'b0);
        end
        next(); rst_n = 1'b1; settle();

        for (int r = 0; r < 15; r++) begin
            next();
            drive(tbl[r].ir, tbl[r].ia, tbl[r].lr, tbl[r].lw, tbl[r].lb, tbl[r].la, tbl[r].wd, tbl[r].q);
            settle();
            for (int d = 0; d < ND; d++) begin
                chk($sformatf("r%0d_if_gnt_d%0d", r, d), if_gnt_v[d], tbl[r].e_ig);
                chk($sformatf("r%0d_ls_gnt_d%0d", r, d), ls_gnt_v[d], tbl[r].e_lg);
                chk($sformatf("r%0d_mem_req_d%0d", r, d), mreq_v[d], tbl[r].e_ig | tbl[r].e_lg);
                chk($sformatf("r%0d_mem_we_d%0d", r, d), mwe_v[d], tbl[r].e_we);
                chk($sformatf("r%0d_mem_be_d%0d", r, d), mbe_v[d], tbl[r].e_be);
                chk($sformatf("r%0d_stall_d%0d", r, d), stall_v[d], tbl[r].e_stall);
                if (tbl[r].e_ig | tbl[r].e_lg)
                    chk($sformatf("r%0d_mem_addr_d%0d", r, d), maddr_v[d], tbl[r].e_addr);
                if (tbl[r].e_we)
                    chk($sformatf("r%0d_mem_wdata_d%0d", r, d), mwdata_v[d], tbl[r].wd);
            end
        end
        chk("store_merge_0x40", mem[16], 32'h5A5ABEEF);

        drive(0, 0, 0, 0, 4'h0, 0, 0, 0);
        repeat (4) begin next(); settle(); end
        for (int d = 0; d < ND; d++) chk($sformatf("drained_idle_d%0d", d), idle_v[d], 1'b1);

        // Quiesce raised the cycle after a fetch grant while a load waits.
        next(); drive(1, 32'h20, 0, 0, 4'h0, 0, 0, 0); settle();
        for (int d = 0; d < ND; d++) chk($sformatf("q_if_gnt_d%0d", d), if_gnt_v[d], 1'b1);
        for (int k = 1; k <= 4; k++) begin
            next(); drive(0, 0, 1, 0, 4'hF, 32'h104, 0, 1); settle();
            for (int d = 0; d < ND; d++) begin
                chk($sformatf("q%0d_ls_gnt_d%0d", k, d), ls_gnt_v[d], 1'b0);
                chk($sformatf("q%0d_idle_d%0d", k, d), idle_v[d], k >= d + 2);
            end
            chk($sformatf("q%0d_if_rvalid_lat3", k), if_rv_v[2], k == 3);
        end
        next(); drive(0, 0, 1, 0, 4'hF, 32'h104, 0, 0); settle();
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("unq_ls_gnt_d%0d", d), ls_gnt_v[d], 1'b1);
            chk($sformatf("unq_stall_d%0d", d), stall_v[d], 16'd11);
        end
        next(); drive(0, 0, 0, 0, 4'h0, 0, 0, 0); settle();

        // Reset one cycle after a fetch grant discards the in-flight read.
        next(); drive(1, 32'h24, 0, 0, 4'h0, 0, 0, 0); settle();
        for (int d = 0; d < ND; d++) chk($sformatf("pre_rst_if_gnt_d%0d", d), if_gnt_v[d], 1'b1);
        next(); rst_n = 1'b0; drive(0, 0, 0, 0, 4'h0, 0, 0, 0); settle();
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("mid_rst_if_rvalid_d%0d", d), if_rv_v[d], 1'b0);
            chk($sformatf("mid_rst_idle_d%0d", d), idle_v[d], 1'b1);
            chk($sformatf("mid_rst_stall_d%0d", d), stall_v[d], 16'd0);
        end
        next(); settle();
        next(); rst_n = 1'b1; settle();
        repeat (4) begin next(); settle(); end
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("post_rst_mreq_d%0d", d), mreq_v[d], 1'b0);
            chk($sformatf("post_rst_idle_d%0d", d), idle_v[d], 1'b1);
        end
        next(); drive(1, 32'h28, 1, 0, 4'hF, 32'h10C, 0, 0); settle();
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("post_rst_if_gnt_d%0d", d), if_gnt_v[d], 1'b1);
            chk($sformatf("post_rst_ls_gnt_d%0d", d), ls_gnt_v[d], 1'b0);
        end
        next(); drive(0, 0, 0, 0, 4'h0, 0, 0, 0); settle();
        repeat (4) begin next(); settle(); end

        // Starve LS under quiesce long enough to saturate the stall counter.
        next(); rst_n = 1'b0; settle();
        next(); rst_n = 1'b1; drive(0, 0, 1, 0, 4'hF, 32'h110, 0, 1); settle();
        for (int k = 1; k <= 65540; k++) begin
            next(); settle();
            if (k == 65534) chk("sat_minus1", stall_v[0], 16'hFFFE);
            if (k == 65535) chk("sat_reach", stall_v[0], 16'hFFFF);
            if (k == 65540) begin
                for (int d = 0; d < ND; d++) begin
                    chk($sformatf("sat_hold_d%0d", d), stall_v[d], 16'hFFFF);
                    chk($sformatf("sat_ls_gnt_d%0d", d), ls_gnt_v[d], 1'b0);
                end
            end
        end
        next(); drive(0, 0, 0, 0, 4'h0, 0, 0, 0); settle();
        chk("sat_after_release", stall_v[0], 16'hFFFF);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
